// File: rtl/conv_cfg_pkg.sv
// Shared configuration for the convolution result capture path.
// Holds the sample width, frame geometry and the capture FSM state type.
package conv_cfg_pkg;

  localparam int T       = 16;
  localparam int X_COUNT = 32;
  localparam int F_COUNT = 8;
  localparam int Y_COUNT = X_COUNT - F_COUNT + 1;

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } cap_state_t;

endpackage

// File: rtl/y_buf_mem.sv
// Single-write / single-read result buffer with a registered read port.
// A read and a write to the same address in one cycle return the old word.
module y_buf_mem #(
  parameter int T    = 16,
  parameter int SIZE = 25,
  parameter int AW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [T-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [T-1:0] rd_data
);

  localparam logic [AW:0] LIMIT = (AW+1)'(SIZE);

  logic signed [T-1:0] mem [SIZE];
  logic                rd_in_range;

  assign rd_in_range = ({1'b0, rd_addr} < LIMIT);

  // Array is deliberately not reset so a reset never disturbs captured data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/conv_y_capture.sv
// Captures one frame of convolution results into a buffer, tracks the frame
// peak and holds the frame for host readout until release_buf rearms capture.
//
// state   | meaning
// CAPTURE | accepting samples, wr_ptr walks 0..Y_COUNT-1
// HOLD    | frame complete, buffer frozen until release_buf
module conv_y_capture #(
  parameter int T       = conv_cfg_pkg::T,
  parameter int Y_COUNT = conv_cfg_pkg::Y_COUNT,
  parameter int ADDR_Y  = $clog2(Y_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_y,
  input  logic                s_valid_y,
  output logic                s_ready_y,
  input  logic                rd_en,
  input  logic [ADDR_Y-1:0]   rd_addr,
  output logic signed [T-1:0] rd_data,
  output logic                rd_valid,
  output logic                frame_done,
  input  logic                release_buf,
  output logic signed [T-1:0] peak_val,
  output logic [ADDR_Y-1:0]   peak_idx,
  output logic [7:0]          frame_cnt
);

  import conv_cfg_pkg::*;

  localparam logic [ADDR_Y-1:0] LAST = ADDR_Y'(Y_COUNT - 1);

  cap_state_t        state;
  logic [ADDR_Y-1:0] wr_ptr;
  logic              hs;
  logic              wr_en;

  // Ready and done come straight off the state flop: no path from s_valid_y.
  assign s_ready_y  = (state == CAPTURE);
  assign frame_done = (state == HOLD);
  assign hs         = s_valid_y & s_ready_y;
  assign wr_en      = hs & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CAPTURE;
      wr_ptr    <= '0;
      frame_cnt <= '0;
      peak_val  <= '0;
      peak_idx  <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (hs) begin
            // First sample of a frame always seeds the peak; ties keep the earlier index.
            if ((wr_ptr == '0) || (s_data_in_y > peak_val)) begin
              peak_val <= s_data_in_y;
              peak_idx <= wr_ptr;
            end
            if (wr_ptr == LAST) begin
              wr_ptr    <= '0;
              state     <= HOLD;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_Y'(1);
            end
          end
        end
        HOLD: begin
          if (release_buf) begin
            state <= CAPTURE;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  y_buf_mem #(
    .T   (T),
    .SIZE(Y_COUNT),
    .AW  (ADDR_Y)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(s_data_in_y),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_conv_y_capture.sv
// Self-checking bench for conv_y_capture: a cycle model tracks capture state,
// buffer, peak and frame count; reads are scored through an expected-data queue.
module tb_conv_y_capture;

  localparam int T  = 16;
  localparam int Y  = 25;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [T-1:0] s_data_in_y;
  logic                s_valid_y;
  logic                s_ready_y;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic signed [T-1:0] rd_data;
  logic                rd_valid;
  logic                frame_done;
  logic                release_buf;
  logic signed [T-1:0] peak_val;
  logic [AW-1:0]       peak_idx;
  logic [7:0]          frame_cnt;

  always #5 clk = ~clk;

  conv_y_capture dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in_y(s_data_in_y),
    .s_valid_y  (s_valid_y),
    .s_ready_y  (s_ready_y),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .release_buf(release_buf),
    .peak_val   (peak_val),
    .peak_idx   (peak_idx),
    .frame_cnt  (frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mem [32];
  int m_ptr  = 0;
  bit m_hold = 0;
  int m_cnt  = 0;
  int m_peak = 0;
  int m_idx  = 0;
  int cur_val = 0;
  int rd_q [$];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs currently applied, then compare.
  task automatic step();
    bit hs;
    bit had_rd;
    hs     = s_valid_y && !m_hold && !reset;
    had_rd = rd_en && !reset;
    if (had_rd) rd_q.push_back((int'(rd_addr) < Y) ? m_mem[rd_addr] : 0);
    if (reset) begin
      m_hold = 0; m_ptr = 0; m_cnt = 0; m_peak = 0; m_idx = 0;
    end else if (hs) begin
      m_mem[m_ptr] = cur_val;
      if (m_ptr == 0 || cur_val > m_peak) begin
        m_peak = cur_val;
        m_idx  = m_ptr;
      end
      if (m_ptr == Y - 1) begin
        m_ptr = 0; m_hold = 1; m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_ptr++;
      end
    end else if (m_hold && release_buf) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
    check("s_ready_y", int'(s_ready_y), int'(!m_hold));
    check("frame_done", int'(frame_done), int'(m_hold));
    check("peak_val", int'(peak_val), m_peak);
    check("peak_idx", int'(peak_idx), m_idx);
    check("frame_cnt", int'(frame_cnt), m_cnt);
    if (had_rd) begin
      check("rd_valid", int'(rd_valid), 1);
      check("rd_data", int'(rd_data), rd_q.pop_front());
    end else begin
      check("rd_valid_idle", int'(rd_valid), 0);
    end
  endtask

  task automatic idle_inputs();
    s_valid_y   = 1'b0;
    cur_val     = 0;
    s_data_in_y = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    release_buf = 1'b0;
  endtask

  task automatic send(input bit valid, input int v);
    s_valid_y   = valid;
    cur_val     = v;
    s_data_in_y = v[T-1:0];
    step();
    s_valid_y   = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < Y; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      step();
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic release_frame();
    release_buf = 1'b1;
    step();
    release_buf = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_ready", int'(s_ready_y), 1);
    reset = 1'b0;

    // Continuous frame, value = index*3-10
    for (int i = 0; i < Y; i++) send(1, i * 3 - 10);
    check("f1_done", int'(frame_done), 1);
    check("f1_ready", int'(s_ready_y), 0);
    check("f1_cnt", int'(frame_cnt), 1);
    check("f1_peak", int'(peak_val), 62);
    check("f1_idx", int'(peak_idx), 24);
    read_all();
    rd_en = 1'b1; rd_addr = AW'(31); step(); rd_en = 1'b0;

    // HOLD ignores incoming samples
    for (int i = 0; i < 10; i++) send(1, 32'h7FFF);
    read_all();
    release_frame();
    check("rel_ready", int'(s_ready_y), 1);
    release_frame();  // ignored in CAPTURE

    // Random valid gaps with concurrent random reads
    for (int c = 0; c < 200 && !m_hold; c++) begin
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 31));
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768);
    end
    rd_en = 1'b0;
    check("rand_done", int'(frame_done), 1);
    read_all();
    release_frame();

    // Peak first occurrence
    send(1, 5); send(1, -3); send(1, 9); send(1, 9);
    for (int i = 4; i < Y; i++) send(1, -100);
    check("pk_val", int'(peak_val), 9);
    check("pk_idx", int'(peak_idx), 2);
    release_frame();
    for (int i = 0; i < Y; i++) send(1, -7);
    check("neg_val", int'(peak_val), -7);
    check("neg_idx", int'(peak_idx), 0);
    release_frame();

    // Reset mid-frame together with a valid sample
    for (int i = 0; i < 12; i++) send(1, 100 + i);
    reset = 1'b1;
    send(1, 555);
    reset = 1'b0;
    check("mid_rst_cnt", int'(frame_cnt), 0);
    for (int i = 0; i < Y; i++) send(1, 200 - i);
    check("post_rst_cnt", int'(frame_cnt), 1);
    check("post_rst_idx", int'(peak_idx), 0);
    read_all();
    rd_en = 1'b1; rd_addr = AW'(31); step(); rd_en = 1'b0;
    step();

    // Frame counter wrap
    reset = 1'b1; step(); reset = 1'b0;
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < Y; i++) send(1, f + i);
      release_frame();
    end
    check("wrap_cnt", int'(frame_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
